// File: rtl/qam_frame_scheduler_pkg.sv
// Shared definitions for the QAM frame scheduler: phase encoding and
// counter sizing.
package qam_ctrl_pkg;

   localparam int PHASE_W = 2;

   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE = 2'd0,
      PH_PRE  = 2'd1,
      PH_PAY  = 2'd2,
      PH_GRD  = 2'd3
   } phase_t;

   // Bit counter width: enough to count 0..2*longest_phase-1.
   function automatic int cnt_width(input int pre_len, input int pay_len, input int guard_len);
      int m1;
      int m2;
      m1 = (pay_len > pre_len) ? pay_len : pre_len;
      m2 = (guard_len > m1) ? guard_len : m1;
      return (m2 < 1) ? 1 : $clog2(2 * m2);
   endfunction

endpackage

// File: rtl/qam_frame_scheduler_if.sv
// Control and serial-stream bundle between the modulator top level and
// the frame scheduler.
interface qam_frame_scheduler_if;
   import qam_ctrl_pkg::*;

   logic               start;
   logic               stop;
   logic               cont;
   logic               src_bit;
   logic               src_en;
   logic               bit_out;
   logic               bit_valid;
   logic               sym_en;
   logic [PHASE_W-1:0] phase;
   logic               busy;
   logic               frame_done;

   // Controller / source side.
   modport master (
      output start, stop, cont, src_bit,
      input  src_en, bit_out, bit_valid, sym_en, phase, busy, frame_done
   );

   // Scheduler side.
   modport slave (
      input  start, stop, cont, src_bit,
      output src_en, bit_out, bit_valid, sym_en, phase, busy, frame_done
   );

endinterface

// File: rtl/qam_frame_scheduler_bit_rate_div.sv
// Bit-rate prescaler: counts 0..DIV-1 and flags the last count as the
// per-bit tick. Held at zero while clr is high.
module bit_rate_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt_r;

   // Prescaler counter with clear and wrap at DIV-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en) begin
         if (cnt_r == LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + PW'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = en && !clr && (cnt_r == LAST);

endmodule

// File: rtl/qam_frame_scheduler.sv
// Frame-level sequencer for the QAM modulator: frames the serial stream as
// preamble / payload / guard, strobes the bit and symbol stages and pulls
// payload bits from the m-sequence source.
module qam_frame_scheduler
   import qam_ctrl_pkg::*;
#(
   parameter int                   DIV         = 4,
   parameter int                   PRE_LEN     = 4,
   parameter int                   PAY_LEN     = 16,
   parameter int                   GUARD_LEN   = 2,
   parameter logic [2*PRE_LEN-1:0] PRE_PATTERN = 8'b1100_1001
) (
   input logic                  clk,
   input logic                  rst,
   qam_frame_scheduler_if.slave bus
);

   localparam int            CW       = cnt_width(PRE_LEN, PAY_LEN, GUARD_LEN);
   localparam int            PW       = 2 * PRE_LEN;
   localparam logic [CW-1:0] PRE_LAST = CW'(2 * PRE_LEN - 1);
   localparam logic [CW-1:0] PAY_LAST = CW'(2 * PAY_LEN - 1);
   localparam logic [CW-1:0] GRD_LAST = (GUARD_LEN > 0) ? CW'(2 * GUARD_LEN - 1) : '0;

   phase_t        phase_r, phase_n;
   logic [CW-1:0] cnt_r, cnt_n;
   logic [PW-1:0] pre_sr_r, pre_sr_n;
   logic          stop_pend_r, stop_pend_n;
   logic          bit_out_r, bit_out_n;
   logic          bit_valid_r, bit_valid_n;
   logic          src_en_r, src_en_n;
   logic          sym_flag_r, sym_flag_n;
   logic          sym_en_r;
   logic          frame_done_r, frame_done_n;
   logic          busy_r;
   logic          tick_s;
   logic          idle_s;
   logic          stop_req_s;

   assign idle_s     = (phase_r == PH_IDLE);
   // A stop seen this cycle acts just like one latched earlier.
   assign stop_req_s = bus.stop | stop_pend_r;

   bit_rate_div #(.DIV(DIV)) u_div (
      .clk  (clk),
      .rst  (rst),
      .clr  (idle_s),
      .en   (!idle_s),
      .tick (tick_s)
   );

   // Phase sequencing, bit counting and next values of the registered strobes.
   always_comb begin
      phase_n      = phase_r;
      cnt_n        = cnt_r;
      pre_sr_n     = pre_sr_r;
      bit_out_n    = 1'b0;
      bit_valid_n  = 1'b0;
      src_en_n     = 1'b0;
      sym_flag_n   = 1'b0;
      frame_done_n = 1'b0;
      case (phase_r)
         PH_IDLE: begin
            if (bus.start && !bus.stop) begin
               phase_n  = PH_PRE;
               cnt_n    = '0;
               pre_sr_n = PRE_PATTERN;
            end else begin
               phase_n  = PH_IDLE;
               cnt_n    = '0;
            end
         end
         PH_PRE: begin
            if (tick_s) begin
               bit_out_n   = pre_sr_r[PW-1];
               bit_valid_n = 1'b1;
               sym_flag_n  = cnt_r[0];
               pre_sr_n    = {pre_sr_r[PW-2:0], 1'b0};
               if (cnt_r[0] && stop_req_s) begin
                  phase_n = PH_IDLE;
                  cnt_n   = '0;
               end else if (cnt_r == PRE_LAST) begin
                  phase_n = PH_PAY;
                  cnt_n   = '0;
               end else begin
                  cnt_n   = cnt_r + CW'(1);
               end
            end else begin
               cnt_n = cnt_r;
            end
         end
         PH_PAY: begin
            if (tick_s) begin
               bit_out_n   = bus.src_bit;
               bit_valid_n = 1'b1;
               src_en_n    = 1'b1;
               sym_flag_n  = cnt_r[0];
               if (cnt_r[0] && stop_req_s) begin
                  phase_n = PH_IDLE;
                  cnt_n   = '0;
               end else if (cnt_r == PAY_LAST) begin
                  cnt_n = '0;
                  if (GUARD_LEN > 0) begin
                     phase_n = PH_GRD;
                  end else begin
                     // No guard: the frame ends on the last payload bit.
                     frame_done_n = 1'b1;
                     if (bus.cont && !stop_req_s) begin
                        phase_n  = PH_PRE;
                        pre_sr_n = PRE_PATTERN;
                     end else begin
                        phase_n  = PH_IDLE;
                     end
                  end
               end else begin
                  cnt_n = cnt_r + CW'(1);
               end
            end else begin
               cnt_n = cnt_r;
            end
         end
         PH_GRD: begin
            if (tick_s) begin
               if (cnt_r == GRD_LAST) begin
                  cnt_n        = '0;
                  frame_done_n = 1'b1;
                  if (bus.cont && !stop_req_s) begin
                     phase_n  = PH_PRE;
                     pre_sr_n = PRE_PATTERN;
                  end else begin
                     phase_n  = PH_IDLE;
                  end
               end else begin
                  cnt_n = cnt_r + CW'(1);
               end
            end else begin
               cnt_n = cnt_r;
            end
         end
         default: begin
            phase_n = PH_IDLE;
            cnt_n   = '0;
         end
      endcase
      // Stop stays latched until the scheduler lands in IDLE.
      if (phase_n == PH_IDLE) begin
         stop_pend_n = 1'b0;
      end else if (bus.stop) begin
         stop_pend_n = 1'b1;
      end else begin
         stop_pend_n = stop_pend_r;
      end
   end

   // Phase state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r <= PH_IDLE;
      end else begin
         phase_r <= phase_n;
      end
   end

   // Counters, stop latch and registered output strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r        <= '0;
         pre_sr_r     <= '0;
         stop_pend_r  <= 1'b0;
         bit_out_r    <= 1'b0;
         bit_valid_r  <= 1'b0;
         src_en_r     <= 1'b0;
         sym_flag_r   <= 1'b0;
         sym_en_r     <= 1'b0;
         frame_done_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         cnt_r        <= cnt_n;
         pre_sr_r     <= pre_sr_n;
         stop_pend_r  <= stop_pend_n;
         bit_out_r    <= bit_out_n;
         bit_valid_r  <= bit_valid_n;
         src_en_r     <= src_en_n;
         sym_flag_r   <= sym_flag_n;
         // Symbol strobe trails the Q-bit valid by one cycle.
         sym_en_r     <= sym_flag_r;
         frame_done_r <= frame_done_n;
         busy_r       <= (phase_n != PH_IDLE);
      end
   end

   assign bus.phase      = phase_r;
   assign bus.busy       = busy_r;
   assign bus.bit_out    = bit_out_r;
   assign bus.bit_valid  = bit_valid_r;
   assign bus.src_en     = src_en_r;
   assign bus.sym_en     = sym_en_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_qam_frame_scheduler.sv
// Scoreboard bench for qam_frame_scheduler (DIV=4, PRE_LEN=2, PAY_LEN=3,
// GUARD_LEN=1, plus a GUARD_LEN=0 build).
module tb_qam_frame_scheduler;
   import qam_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   qam_frame_scheduler_if bus();
   qam_frame_scheduler_if bus0();

   qam_frame_scheduler #(
      .DIV(4), .PRE_LEN(2), .PAY_LEN(3), .GUARD_LEN(1), .PRE_PATTERN(4'b1011)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   qam_frame_scheduler #(
      .DIV(4), .PRE_LEN(2), .PAY_LEN(3), .GUARD_LEN(0), .PRE_PATTERN(4'b1011)
   ) dut_g0 (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   first_valid_cyc = -1;
   int   n_valid = 0, n_src = 0, n_sym = 0, n_done = 0;
   int   n0_valid = 0, n0_done = 0;
   logic exp_q[$];
   logic [4:0] lfsr = 5'h15;
   logic src_mode = 1'b0;

   function automatic logic [4:0] lfsr_step(input logic [4:0] s);
      return {s[0] ^ s[3], s[4:1]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // m-sequence source model, advanced by the scheduler's src_en
   always @(posedge clk) if (bus.src_en) lfsr <= lfsr_step(lfsr);
   assign bus.src_bit  = src_mode ? lfsr[0] : 1'b1;
   assign bus0.src_bit = 1'b1;

   // output monitor: pop expected bits and count strobes
   always @(negedge clk) begin
      if (bus.bit_valid) begin
         n_valid++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (exp_q.size() == 0) check_eq("bit_unexpected", 32'(bus.bit_valid), 32'd0);
         else check_eq("bit_out", 32'(bus.bit_out), 32'(exp_q.pop_front()));
      end
      if (bus.src_en) begin
         n_src++;
         check_eq("src_en_bit", 32'(bus.bit_out), 32'(bus.src_bit));
      end
      if (bus.sym_en) n_sym++;
      if (bus.frame_done) n_done++;
      if (bus0.bit_valid) n0_valid++;
      if (bus0.frame_done) n0_done++;
   end

   task automatic clear_counts();
      n_valid = 0; n_src = 0; n_sym = 0; n_done = 0;
      n0_valid = 0; n0_done = 0; first_valid_cyc = -1;
   endtask

   task automatic push_pre();
      logic [3:0] pat;
      pat = 4'b1011;
      for (int i = 3; i >= 0; i--) exp_q.push_back(pat[i]);
   endtask

   task automatic push_ones(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
   endtask

   task automatic push_lfsr(input int n);
      logic [4:0] m;
      m = lfsr;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(m[0]);
         m = lfsr_step(m);
      end
   endtask

   task automatic start_frame();
      bus.start = 1'b1;
      @(posedge clk);
      #1 start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int which, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (which == 0 && bus.frame_done === 1'b1) begin at = cyc; break; end
         if (which == 1 && bus0.frame_done === 1'b1) begin at = cyc; break; end
      end
   endtask

   int t1, t2, s0;

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
      bus0.start = 1'b0; bus0.stop = 1'b0; bus0.cont = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_phase", 32'(bus.phase), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
      check_eq("rst_strobes", 32'({bus.src_en, bus.sym_en, bus.frame_done, bus.bit_out}), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single frame, src_bit tied high
      clear_counts(); push_pre(); push_ones(6);
      start_frame();
      check_eq("t1_busy", 32'(bus.busy), 32'd1);
      check_eq("t1_phase_pre", 32'(bus.phase), 32'd1);
      wait_done(0, 100, t1);
      check_eq("t1_frame_len", t1 - start_cyc, 32'd48);
      check_eq("t1_first_bit", first_valid_cyc - start_cyc, 32'd4);
      check_eq("t1_phase_end", 32'(bus.phase), 32'd0);
      @(negedge clk);
      check_eq("t1_bits", n_valid, 32'd10);
      check_eq("t1_sym_en", n_sym, 32'd5);
      check_eq("t1_src_en", n_src, 32'd6);
      check_eq("t1_done", n_done, 32'd1);
      check_eq("t1_queue", exp_q.size(), 32'd0);

      // payload from m-sequence model
      src_mode = 1'b1;
      clear_counts(); push_pre(); push_lfsr(6);
      start_frame();
      wait_done(0, 100, t1);
      @(negedge clk);
      check_eq("t2_src_en", n_src, 32'd6);
      check_eq("t2_queue", exp_q.size(), 32'd0);
      src_mode = 1'b0;
      repeat (3) @(negedge clk);

      // continuous mode: two back-to-back frames
      clear_counts(); push_pre(); push_ones(6); push_pre(); push_ones(6);
      bus.cont = 1'b1;
      start_frame();
      wait_done(0, 100, t1);
      check_eq("t3_first_len", t1 - start_cyc, 32'd48);
      check_eq("t3_no_gap_phase", 32'(bus.phase), 32'd1);
      bus.cont = 1'b0;
      wait_done(0, 100, t2);
      check_eq("t3_period", t2 - t1, 32'd48);
      check_eq("t3_phase_end", 32'(bus.phase), 32'd0);
      @(negedge clk);
      check_eq("t3_bits", n_valid, 32'd20);
      check_eq("t3_done", n_done, 32'd2);
      check_eq("t3_queue", exp_q.size(), 32'd0);

      // abort during the I bit of the second payload symbol
      clear_counts(); push_pre(); push_ones(4);
      start_frame();
      repeat (28) @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t4_phase_q", 32'(bus.phase), 32'd2);
      @(negedge clk);
      check_eq("t4_phase_idle", 32'(bus.phase), 32'd0);
      repeat (20) @(negedge clk);
      check_eq("t4_bits", n_valid, 32'd8);
      check_eq("t4_sym_en", n_sym, 32'd4);
      check_eq("t4_no_done", n_done, 32'd0);
      check_eq("t4_queue", exp_q.size(), 32'd0);

      // start and stop together in IDLE
      clear_counts();
      bus.start = 1'b1; bus.stop = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("t5_phase", 32'(bus.phase), 32'd0);
      check_eq("t5_busy", 32'(bus.busy), 32'd0);
      check_eq("t5_bits", n_valid, 32'd0);

      // start while busy is ignored
      clear_counts(); push_pre(); push_ones(6);
      start_frame();
      repeat (10) @(negedge clk);
      bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
      repeat (15) @(negedge clk);
      bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
      wait_done(0, 100, t1);
      check_eq("t6_frame_len", t1 - start_cyc, 32'd48);
      repeat (10) @(negedge clk);
      check_eq("t6_phase_end", 32'(bus.phase), 32'd0);
      check_eq("t6_bits", n_valid, 32'd10);
      check_eq("t6_done", n_done, 32'd1);

      // GUARD_LEN=0 build
      clear_counts();
      bus0.start = 1'b1;
      @(posedge clk);
      #1 s0 = cyc;
      @(negedge clk);
      bus0.start = 1'b0;
      wait_done(1, 100, t1);
      check_eq("t7_frame_len", t1 - s0, 32'd40);
      check_eq("t7_phase_end", 32'(bus0.phase), 32'd0);
      @(negedge clk);
      check_eq("t7_bits", n0_valid, 32'd10);
      check_eq("t7_done", n0_done, 32'd1);

      // asynchronous reset mid-preamble
      clear_counts(); push_pre(); push_ones(6);
      start_frame();
      repeat (12) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_eq("t8_phase", 32'(bus.phase), 32'd0);
      check_eq("t8_busy", 32'(bus.busy), 32'd0);
      check_eq("t8_bit_valid", 32'(bus.bit_valid), 32'd0);
      check_eq("t8_bit_out", 32'(bus.bit_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check_eq("t8_no_done", n_done, 32'd0);
      src_mode = 1'b1;
      clear_counts(); push_pre(); push_lfsr(6);
      start_frame();
      wait_done(0, 100, t1);
      check_eq("t8_frame_len", t1 - start_cyc, 32'd48);
      @(negedge clk);
      check_eq("t8_bits", n_valid, 32'd10);
      check_eq("t8_sym_en", n_sym, 32'd5);
      check_eq("t8_queue", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/qam_frame_scheduler.md
# qam_frame_scheduler

Frame-level sequencer for the digital QAM modulator. Derives the bit-rate and symbol-rate strobes from the single system clock and frames the serial stream as preamble, payload and guard. Drives the serial bit into the serial-to-parallel stage, advances the m-sequence source only during payload, and tells the level-transfer stages when a complete I/Q symbol is ready. Accepts start/stop/continuous control from the test or top level.

## Interface
- DIV, 4: clk cycles per serial bit; legal range ≥2.
- PRE_LEN, 4: preamble length in symbols; legal range ≥1.
- PAY_LEN, 16: payload length in symbols; legal range ≥1.
- GUARD_LEN, 2: guard length in symbols; 0 is legal.
- PRE_PATTERN, 8'b1100_1001: preamble bits, 2*PRE_LEN wide, sent MSB first.

- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request to begin a frame; honoured only in IDLE.
- stop  in  1  abort request; latched until it is acted on.
- cont  in  1  continuous mode; sampled at the end of the guard phase.
- src_bit  in  1  payload bit from the m-sequence generator.
- src_en  out  1  one-cycle advance strobe to the m-sequence generator.
- bit_out  out  1  serial bit to serial-to-parallel; registered.
- bit_valid  out  1  one-cycle strobe qualifying bit_out.
- sym_en  out  1  one-cycle strobe to both level-transfer stages.
- phase  out  2  current phase: IDLE=0, PRE=1, PAY=2, GRD=3.
- busy  out  1  high whenever phase ≠ IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes normally.

## Operation
- Prescaler runs 0..DIV-1 and is held at 0 in IDLE. A tick fires when it reaches DIV-1.
- Each symbol is 2 bits: the first is I, the second is Q. bit_cnt counts 0..2*LEN-1 within the current phase. A symbol boundary is the tick of an odd bit_cnt.
- **IDLE:** start=1 with no stop pending → PRE. The prescaler and bit_cnt clear.
- **PRE:** on each tick, bit_out = PRE_PATTERN[2*PRE_LEN-1-bit_cnt] and bit_valid=1. After the last bit → PAY.
- **PAY:** on each tick, src_en=1 and bit_out = src_bit sampled in that same cycle; bit_valid=1. After bit 2*PAY_LEN-1 → GRD, or → IDLE if GUARD_LEN=0 (the end-of-guard rules then apply immediately).
- **GRD:** ticks count silently; bit_valid=0, src_en=0, bit_out=0. At the end of the guard, frame_done pulses. If cont=1 and no stop is pending → PRE; otherwise → IDLE.
- **sym_en:** pulses one cycle after the bit_valid of every odd bit_cnt, in PRE and PAY only.
- **stop:**
  - Sets stop_pend.
  - In PRE or PAY, it takes effect at the next symbol boundary. The phase goes to IDLE after that boundary's bit; that symbol's sym_en still fires and frame_done does not.
  - In GRD, the guard completes and frame_done pulses, then the phase goes to IDLE.
  - In IDLE, it clears immediately with no effect.
  - stop_pend clears on entry to IDLE.
- start while busy is ignored. start and stop in the same cycle in IDLE: stop wins and the phase stays IDLE.

## Timing
- Reset values: phase=IDLE, all strobes 0, bit_out=0, busy=0, counters 0, stop_pend=0.
- Start accepted at edge 0 → phase=PRE and busy=1 after edge 0. The first bit_valid is high after edge DIV.
- bit_valid, src_en and bit_out change on the tick edge and are high for exactly one cycle per bit. Bit period is DIV cycles.
- sym_en is high for the one cycle following the Q-bit bit_valid.
- frame_done is high for the one cycle after the final guard tick, coincident with phase returning to IDLE or PRE.
- Symbol period is 2*DIV cycles. Frame length is 2*DIV*(PRE_LEN+PAY_LEN+GUARD_LEN) cycles.
- Asserting rst mid-frame forces the reset values asynchronously. No frame_done is produced.

## Structure
- Package qam_ctrl_pkg holds:
  - the phase encoding constants PH_IDLE, PH_PRE, PH_PAY, PH_GRD;
  - the width function for the counters, $clog2(2*max(PRE_LEN,PAY_LEN,GUARD_LEN)).
- Sub-module bit_rate_div holds the prescaler. Inputs: clk, rst, clr, en. Output: tick.
- The phase FSM, bit counter and stop latch sit in the top module.

## Test plan
All scenarios use DIV=4, PRE_LEN=2, PRE_PATTERN=4'b1011, PAY_LEN=3, GUARD_LEN=1.
- **Single frame:** start pulse, src_bit tied 1 → bit_out sequence 1,0,1,1,1,1,1,1,1,1 on bit_valid every 4 cycles. sym_en count 5. frame_done pulses 48 cycles after the start edge. phase ends 0.
- **Payload source:** src_bit driven from an m-sequence model → exactly 6 src_en pulses. Each bit_out equals src_bit in its src_en cycle.
- **Continuous:** cont=1 → frame_done pulses every 48 cycles. The preamble 1,0,1,1 restarts with no idle gap.
- **Mid-payload abort:** stop asserted during the I bit of the second payload symbol → that symbol's Q bit and sym_en still occur, then phase=0. No frame_done.
- **Edge cases:**
  - start and stop in the same cycle in IDLE → stays IDLE.
  - start while busy → ignored; frame timing unchanged.
  - GUARD_LEN=0 build → PAY goes directly to IDLE and frame_done pulses.
- **Async reset mid-preamble:** rst low → all outputs 0 immediately. The next start produces a full, correct frame.
